// File: rtl/cpa_arb_pkg.sv
// Shared definitions for the round-robin arbiter in front of the CPA datapath.
package cpa_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 4;

    // Result slot occupancy: EMPTY means res_valid is low, FULL means a result is waiting.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

    // Width needed to hold a requester index; a single requester still gets one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W_DEF = id_width(N_REQ_DEF);

endpackage

// File: rtl/cpa_arbiter_cpa.sv
// Shared CPA datapath: combines the two operands bitwise with XOR.
module cpa_arbiter_cpa #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    assign sum = a ^ b;

endmodule

// File: rtl/cpa_arbiter.sv
// Round-robin arbiter feeding N_REQ requesters into one CPA with a single
// registered result slot. A result can be drained and replaced in the same
// cycle, so a continuously ready sink sees one result per clock.
module cpa_arbiter
    import cpa_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    parameter  int W     = W_DEF,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               res_valid,
    output logic [W-1:0]       res_data,
    output logic [ID_W-1:0]    res_id,
    input  logic               res_ready
);

    arb_state_e      state_q, state_d;
    logic [W-1:0]    res_data_q, res_data_d;
    logic [ID_W-1:0] res_id_q, res_id_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [ID_W-1:0] grant_idx;
    logic [N_REQ-1:0] grant_vec;
    logic            slot_free;
    logic            accept;
    logic [W-1:0]    mux_a, mux_b, cpa_sum;

    // First valid requester found searching upward from last+1, wrapping at N_REQ.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                  input logic [ID_W-1:0]  last);
        logic [N_REQ-1:0] pick;
        logic [ID_W-1:0]  idx;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(last) + k) % N_REQ);
            if (!found && valid[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

    // Grant only when the result slot can take a new value and reset is released.
    always_comb begin
        slot_free = (state_q == EMPTY) || res_ready;
        grant_vec = '0;
        if (!rst && slot_free) begin
            grant_vec = rr_pick(req_valid, last_grant_q);
        end
    end

    assign req_ready = grant_vec;
    assign accept    = |grant_vec;

    // Encode the one-hot grant into an index that steers the operand mux.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_vec[i]) begin
                grant_idx = ID_W'(i);
            end
        end
    end

    assign mux_a = req_a[int'(grant_idx)*W +: W];
    assign mux_b = req_b[int'(grant_idx)*W +: W];

    cpa_arbiter_cpa #(
        .W (W)
    ) u_cpa (
        .a   (mux_a),
        .b   (mux_b),
        .sum (cpa_sum)
    );

    // Slot occupancy and result/pointer updates; the pointer only moves on acceptance.
    always_comb begin
        state_d      = state_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (res_ready && !accept) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            res_data_d   = cpa_sum;
            res_id_d     = grant_idx;
            last_grant_d = grant_idx;
        end
    end

    // State registers; reset leaves requester 0 with top priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            res_data_q   <= '0;
            res_id_q     <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
        end else begin
            state_q      <= state_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

endmodule

// File: doc/cpa_arbiter.md
CPA_ARBITER -- requirements
Module: cpa_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the CPA datapath; legal values are 2 to 8.
REQ-002 Parameter W, default 4, operand and result width in bits; matches the CPA datapath.
REQ-003 Port clk, input, 1 bit, single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 Port req_valid, input, N_REQ bits, per-requester operand-valid.
REQ-006 Port req_a, input, N_REQ*W bits, operand A of requester i in bits [i*W +: W].
REQ-007 Port req_b, input, N_REQ*W bits, operand B of requester i in bits [i*W +: W].
REQ-008 Port req_ready, output, N_REQ bits, one-hot-or-zero grant; requester i's operands are taken when req_valid[i] and req_ready[i] are both high at a clock edge.
REQ-009 Port res_valid, output, 1 bit, result register holds a valid result.
REQ-010 Port res_data, output, W bits, CPA result (A XOR B) of the granted requester.
REQ-011 Port res_id, output, clog2(N_REQ) bits, index of the requester that produced res_data.
REQ-012 Port res_ready, input, 1 bit, downstream accepts the result when res_valid and res_ready are both high at a clock edge.

Function
REQ-013 One shared CPA instance; at most one request is accepted per cycle.
REQ-014 The output slot is free when res_valid=0, or when res_valid=1 and res_ready=1 in the same cycle.
REQ-015 req_ready is combinational from req_valid, the priority pointer and slot-free status.
  - It is all-zero when the slot is not free or no req_valid bit is set.
  - Otherwise it has exactly one bit set: the first valid requester searched round-robin from index (last_grant+1) mod N_REQ upward.
REQ-016 On acceptance at edge t, the following are registered at edge t, with 1-cycle latency:
  - res_data = a_i XOR b_i;
  - res_id = i;
  - res_valid = 1;
  - last_grant = i.
REQ-017 On a drain (res_valid and res_ready) with no acceptance, res_valid goes to 0. res_data and res_id hold their values.
REQ-018 A simultaneous drain and acceptance replaces the result with no bubble, sustaining throughput of 1 result per cycle.
REQ-019 While res_valid=1 and res_ready=0, res_data and res_id are held stable and req_ready is all-zero.
REQ-020 last_grant changes only on acceptance. Idle cycles and stalled cycles do not move the pointer.
REQ-021 Fairness: a requester holding req_valid high is granted within N_REQ accepted transactions.
REQ-022 Operand values of non-granted requesters have no effect on any state.
REQ-023 State machine with two states:
  - EMPTY (res_valid=0) goes to FULL on acceptance.
  - FULL goes to EMPTY on a drain without acceptance.
  - FULL stays FULL on stall, or on drain plus acceptance.

Reset
REQ-024 While rst=1, regardless of clk:
  - res_valid = 0;
  - res_data = 0;
  - res_id = 0;
  - last_grant = N_REQ-1, so requester 0 has highest priority after reset.
REQ-025 A result pending when reset asserts mid-operation is discarded and is not presented after reset deasserts.
REQ-026 req_ready is all-zero while rst=1.

Structure
REQ-027 Package cpa_arb_pkg holds:
  - N_REQ and W defaults;
  - the state enum {EMPTY, FULL};
  - the id width constant.
REQ-028 The datapath is one instance of the existing CPA module (W=4), fed through an N_REQ:1 operand mux. No other sub-module is needed.
REQ-029 The round-robin search is a combinational function inside cpa_arbiter.

Verification
REQ-030 Reset then single request: req_valid=0001, a0=4'hA, b0=4'h3, res_ready=1.
  - Required: req_ready=0001.
  - Next cycle: res_valid=1, res_data=4'h9, res_id=0.
REQ-031 All requesters valid continuously, res_ready=1.
  - Required: grants ordered 0,1,2,3,0,...
  - One result per cycle, with res_id following the same order.
REQ-032 Backpressure: res_valid=1 with res_ready=0 for 3 cycles.
  - Required: req_ready=0000 throughout, res_data/res_id stable.
  - On release, the next grant follows the pointer.
REQ-033 Pointer hold: grant requester 2, then idle 5 cycles, then req_valid=0101.
  - Required: requester 0 is granted, since the search starts at 3 and wraps to 0.
REQ-034 Reset mid-operation: assert rst while res_valid=1.
  - Required: res_valid=0 immediately (asynchronous).
  - With req_valid=1111 after release, requester 0 is granted first.
REQ-035 Random traffic with a scoreboard.
  - Every accepted (i, a XOR b) pair appears exactly once, in order.
  - No requester waits more than N_REQ acceptances.
